data_mem_responder: RTL

//  Target side of the CPU core data-memory port: word-organised RAM with combinational read and

---
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Target side of the core data-memory port. Word-organised RAM with
// combinational read and byte-enabled synchronous write. After reset (or a
// clr_req pulse) an FSM zeroes every word before the memory is usable.
// A valid/ready loader port preloads programme data while the core is idle,
// and a sticky halt flag captures core writes to the tohost word.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   dmem_addr/wdata/we/be  core access (byte address, bits [1:0] ignored)
//   dmem_size              access size, informational only
//   dmem_rdata             combinational read data
//   ld_valid/ready/addr/wdata  loader word-write handshake
//   clr_req                restart the clear sequence (from READY)
//   mem_busy               high while clearing
//   halted, tohost_value   sticky halt flag and captured tohost word
//
// state    | meaning
// ST_CLEAR | zeroing word clr_idx_q each cycle, port closed
// ST_READY | normal operation, core and loader may write
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int          ADDR_W        = 10,
  parameter logic [31:0] TOHOST_OFFSET = 32'hFFC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic              dmem_we,
  input  logic [3:0]        dmem_be,
  input  logic [1:0]        dmem_size,
  output logic [31:0]       dmem_rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              clr_req,
  output logic              mem_busy,
  output logic              halted,
  output logic [31:0]       tohost_value
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              halted_q, halted_d;
  logic [31:0]       tohost_q, tohost_d;

  logic [31:0]       mem [DEPTH];

  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              is_ready;
  logic              core_wr;
  logic              halt_hit;
  logic              ld_fire;
  logic              unused_bits;

  // Size is advisory and the byte lanes come from dmem_be; the low address
  // bits select a byte within the word and are not needed for word access.
  assign unused_bits = ^{dmem_size, dmem_addr[1:0]};

  assign in_range = (dmem_addr[31:ADDR_W+2] == '0);
  assign word_idx = dmem_addr[ADDR_W+1:2];
  assign is_ready = (state_q == ST_READY);

  // clr_req wins over any write issued in the same cycle.
  assign core_wr  = is_ready & ~clr_req & dmem_we & in_range & (|dmem_be);
  assign halt_hit = core_wr & (dmem_addr[31:2] == TOHOST_OFFSET[31:2]);
  assign ld_fire  = ld_valid & ld_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      halted_q  <= 1'b0;
      tohost_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      halted_q  <= halted_d;
      tohost_q  <= tohost_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    halted_d  = halted_q;
    tohost_d  = tohost_q;
    unique case (state_q)
      ST_CLEAR: begin
        // Wraps back to zero on the last word, leaving the index ready for
        // the next clear pass.
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == {ADDR_W{1'b1}}) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        clr_idx_d = '0;
        if (clr_req) begin
          state_d  = ST_CLEAR;
          halted_d = 1'b0;
          tohost_d = '0;
        end else if (halt_hit) begin
          halted_d = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (dmem_be[i]) begin
              tohost_d[8*i +: 8] = dmem_wdata[8*i +: 8];
            end
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Outputs
  always_comb begin
    mem_busy     = (state_q == ST_CLEAR);
    ld_ready     = is_ready & ~dmem_we & ~clr_req;
    halted       = halted_q;
    tohost_value = tohost_q;
    dmem_rdata   = '0;
    if (is_ready && in_range) begin
      dmem_rdata = mem[word_idx];
    end
  end

  // RAM array: no reset, the clear pass provides the zero state.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_idx_q] <= '0;
    end else if (core_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_be[i]) begin
          mem[word_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
        end
      end
    end else if (ld_fire) begin
      mem[ld_addr] <= ld_wdata;
    end
  end

endmodule
